sobel_gradient: RTL

SOBEL_GRADIENT -- requirements
Module: sobel_gradient

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/line_buffer.sv | 32 +++
 rtl/sobel_gradient.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient datapath.
//   pixel_t    : 8-bit unsigned greyscale sample
//   column_t   : one window column, [0] = top row, [2] = bottom row
//   window_t   : 3x3 window, [0] = left column, [2] = right column
//   kernel_t   : signed raw gradient, KERNEL_BITS wide (covers -1020..+1020)
//   tap_sum()  : a + 2b + c weighting used by both kernels
package sobel_pkg;

   localparam int unsigned PIXEL_BITS  = 8;
   localparam int unsigned KERNEL_BITS = 11;

   typedef logic [PIXEL_BITS-1:0] pixel_t;
   typedef pixel_t [2:0] column_t;
   typedef column_t [2:0] window_t;
   typedef logic signed [KERNEL_BITS-1:0] kernel_t;

   // Weighted 1-2-1 sum of three pixels; max 1020 fits an 11-bit signed value.
   function automatic kernel_t tap_sum(input pixel_t a, input pixel_t b, input pixel_t c);
      return kernel_t'(a) + kernel_t'({b, 1'b0}) + kernel_t'(c);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line buffer, read-before-write: rd_data_c shows the stored
// word at addr combinationally while wr_data is written on the same edge.
// Contents are not reset.
//   clk       : rising-edge clock
//   wr_en     : write wr_data at addr on this edge
//   addr      : column address
//   wr_data   : pixel to store
//   rd_data_c : pixel currently stored at addr (combinational)
module line_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         addr,
   input  logic [PIXEL_BITS-1:0] wr_data,
   output logic [PIXEL_BITS-1:0] rd_data_c
);

   pixel_t mem [DEPTH];

   assign rd_data_c = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient over a raster-order greyscale frame.
// A gradient for centre (row-1, col-1) is registered on the edge that
// accepts pixel (row, col) when row >= 2 and col >= 2; border centres
// produce nothing.
// Optional feature macro SOBEL_SCALE_EN: outputs are raw Gx/Gy >>> 2.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   pix_in     : unsigned 8-bit pixel, raster order
//   pix_valid  : pix_in accepted this cycle (no backpressure)
//   sof        : with pix_valid, pix_in is pixel (0,0)
//   horz_out   : signed Gx, sign-extended to PRECISION
//   vert_out   : signed Gy, sign-extended to PRECISION
//   grad_valid : horz_out/vert_out updated this cycle
//   frame_done : pulse with the last interior gradient of a frame
module sobel_gradient
   import sobel_pkg::*;
#(
   parameter int unsigned PRECISION  = 16,
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [PIXEL_BITS-1:0]       pix_in,
   input  logic                        pix_valid,
   input  logic                        sof,
   output logic signed [PRECISION-1:0] horz_out,
   output logic signed [PRECISION-1:0] vert_out,
   output logic                        grad_valid,
   output logic                        frame_done
);

   localparam int unsigned COL_BITS = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_BITS = $clog2(IMG_HEIGHT);

   logic [COL_BITS-1:0] col, cur_col;
   logic [ROW_BITS-1:0] row, cur_row;
   logic                last_col, last_row, emit, frame_end;
   pixel_t              lb_prev_c, lb_prev2_c;
   column_t [1:0]       hist;       // two previously accepted columns, [0] older
   window_t             win;
   kernel_t             gx, gy, gx_sel, gy_sel;

   // Position of the pixel on pix_in; sof forces (0,0).
   always_comb begin
      cur_col   = sof ? '0 : col;
      cur_row   = sof ? '0 : row;
      last_col  = (cur_col == COL_BITS'(IMG_WIDTH - 1));
      last_row  = (cur_row == ROW_BITS'(IMG_HEIGHT - 1));
      emit      = pix_valid && (cur_row >= ROW_BITS'(2)) && (cur_col >= COL_BITS'(2));
      frame_end = emit && last_col && last_row;
   end

   // Raster counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : cur_row + ROW_BITS'(1);
         end else begin
            col <= cur_col + COL_BITS'(1);
            row <= cur_row;
         end
      end
   end

   // lb_prev holds row-1, lb_prev2 holds row-2; the older row cascades down.
   line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_BITS)) u_lb_prev (
      .clk       (clk),
      .wr_en     (pix_valid),
      .addr      (cur_col),
      .wr_data   (pix_in),
      .rd_data_c (lb_prev_c)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_BITS)) u_lb_prev2 (
      .clk       (clk),
      .wr_en     (pix_valid),
      .addr      (cur_col),
      .wr_data   (lb_prev_c),
      .rd_data_c (lb_prev2_c)
   );

   // Window = two stored columns plus the incoming column, so the
   // gradient can be registered on the accepting edge itself.
   always_comb begin
      win[0] = hist[0];
      win[1] = hist[1];
      win[2] = {pix_in, lb_prev_c, lb_prev2_c};
      gx = tap_sum(win[2][0], win[2][1], win[2][2]) - tap_sum(win[0][0], win[0][1], win[0][2]);
      gy = tap_sum(win[0][2], win[1][2], win[2][2]) - tap_sum(win[0][0], win[1][0], win[2][0]);
`ifdef SOBEL_SCALE_EN
      gx_sel = gx >>> 2;
      gy_sel = gy >>> 2;
`else
      gx_sel = gx;
      gy_sel = gy;
`endif
   end

   // Column history shift
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
      end else if (pix_valid) begin
         hist[0] <= hist[1];
         hist[1] <= win[2];
      end
   end

   // Registered outputs; gradients hold while no new centre is emitted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         horz_out   <= '0;
         vert_out   <= '0;
         grad_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         grad_valid <= emit;
         frame_done <= frame_end;
         if (emit) begin
            horz_out <= PRECISION'(gx_sel);
            vert_out <= PRECISION'(gy_sel);
         end
      end
   end

endmodule
